// File: rtl/cw_sidetone.sv
// CW sidetone generator: envelope-shaped triangle tone driven by the keyer,
// with programmable frequency/volume/enable and a 3-clk output pipeline.
module cw_sidetone #(
    parameter int unsigned INC_SCALE = 350,
    parameter int unsigned ENV_STEP  = 1,
    parameter int unsigned FREQ_MAX  = 4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         cmd_addr,
    input  logic [31:0]        cmd_data,
    input  logic               cmd_rqst,
    input  logic               cw_keydown,
    input  logic               sample_tick,
    output logic signed [15:0] sidetone,
    output logic               sidetone_valid,
    output logic               sidetone_active
);

    typedef enum logic [1:0] {S_IDLE, S_RISE, S_HOLD, S_FALL} state_t;

    localparam logic [11:0] FREQ_CLAMP = 12'(FREQ_MAX);
    localparam logic [8:0]  STEP9      = 9'(ENV_STEP);

    state_t             r_state;
    logic [7:0]         r_volume;
    logic               r_enable;
    logic [11:0]        r_freq;
    logic [23:0]        r_inc;
    logic [23:0]        r_phase;
    logic [7:0]         r_env;
    logic signed [23:0] r_p1;
    logic [7:0]         r_vol1;
    logic               r_v1;
    logic signed [31:0] r_p2;
    logic               r_v2;

    logic               w_key;
    logic [11:0]        w_freq_wr;
    logic [8:0]         w_env_up;
    logic               w_at_top;
    logic               w_at_zero;
    logic [7:0]         w_env_dn;
    logic [23:0]        w_phase_nx;
    logic [14:0]        w_u;
    logic signed [16:0] w_tri;
    logic signed [25:0] w_prod1;
    logic signed [31:0] w_prod2;
    logic               w_unused;

    always_comb begin
        w_key      = cw_keydown & r_enable & (r_volume != '0);
        w_freq_wr  = (cmd_data[11:0] > FREQ_CLAMP) ? FREQ_CLAMP : cmd_data[11:0];
        w_env_up   = {1'b0, r_env} + STEP9;
        w_at_top   = (w_env_up >= 9'd255);
        w_at_zero  = ({1'b0, r_env} <= STEP9);
        w_env_dn   = w_at_zero ? '0 : (r_env - STEP9[7:0]);
        w_phase_nx = r_phase + r_inc;
        // Fold the upper half of the phase back down to form the triangle.
        w_u        = r_phase[23] ? ~r_phase[22:8] : r_phase[22:8];
        w_tri      = $signed({1'b0, w_u, 1'b0}) - 17'sd32767;
        w_prod1    = 26'(w_tri) * 26'($signed({1'b0, r_env}));
        w_prod2    = 32'(r_p1) * 32'($signed({1'b0, r_vol1}));
        w_unused   = ^cmd_data[31:12];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_volume        <= 8'h40;
            r_enable        <= 1'b1;
            r_freq          <= 12'd600;
            r_inc           <= '0;
            r_phase         <= '0;
            r_env           <= '0;
            r_state         <= S_IDLE;
            r_p1            <= '0;
            r_vol1          <= '0;
            r_v1            <= 1'b0;
            r_p2            <= '0;
            r_v2            <= 1'b0;
            sidetone        <= '0;
            sidetone_valid  <= 1'b0;
            sidetone_active <= 1'b0;
        end else begin
            if (cmd_rqst) begin
                if (cmd_addr == 6'h0F) begin
                    r_volume <= cmd_data[7:0];
                    r_enable <= cmd_data[8];
                end else if (cmd_addr == 6'h10) begin
                    r_freq <= w_freq_wr;
                end
            end
            r_inc <= 24'(r_freq) * 24'(INC_SCALE);

            r_v1 <= sample_tick;
            if (sample_tick) begin
                r_p1   <= w_prod1[23:0];
                r_vol1 <= r_volume;
                case (r_state)
                    S_IDLE: begin
                        r_env   <= '0;
                        r_phase <= '0;
                        if (w_key) begin
                            r_state         <= S_RISE;
                            sidetone_active <= 1'b1;
                        end
                    end
                    S_RISE: begin
                        r_phase <= w_phase_nx;
                        if (!w_key) begin
                            r_state <= S_FALL;
                        end else if (w_at_top) begin
                            r_env   <= 8'd255;
                            r_state <= S_HOLD;
                        end else begin
                            r_env <= w_env_up[7:0];
                        end
                    end
                    S_HOLD: begin
                        r_phase <= w_phase_nx;
                        r_env   <= 8'd255;
                        if (!w_key) r_state <= S_FALL;
                    end
                    S_FALL: begin
                        if (w_key) begin
                            r_phase <= w_phase_nx;
                            r_state <= S_RISE;
                        end else begin
                            r_env <= w_env_dn;
                            if (w_at_zero) begin
                                r_phase         <= '0;
                                r_state         <= S_IDLE;
                                sidetone_active <= 1'b0;
                            end else begin
                                r_phase <= w_phase_nx;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            r_p2           <= w_prod2;
            r_v2           <= r_v1;
            sidetone_valid <= r_v2;
            if (r_v2) sidetone <= r_p2[31:16];
        end
    end

endmodule

// File: doc/cw_sidetone.md
Name: cw_sidetone

Overview:
- Generates the operator's local CW monitor tone, driven by the keyer's `cw_keydown` output.
- Sits directly downstream of the control/keyer stage, on the same 10 MHz `clk` and command bus.
- Produces a click-free, envelope-shaped triangle tone at the audio sample rate, for mixing into the headphone codec stream.
- Frequency, volume and enable are programmed over the `cmd_addr`/`cmd_data`/`cmd_rqst` bus.

Parameters:
- INC_SCALE, 350: phase-increment multiplier per Hz (2^24/48000, rounded) for a 24-bit accumulator at 48 kHz.
- ENV_STEP, 1: envelope change per sample tick. 255 ticks ≈ 5.3 ms ramp at 48 kHz.
- FREQ_MAX, 4000: frequency clamp in Hz.

Ports:
- clk  in  1  system clock (10 MHz).
- rst  in  1  asynchronous active-high reset.
- cmd_addr  in  6  command address.
- cmd_data  in  32  command data.
- cmd_rqst  in  1  command strobe, one clk.
- cw_keydown  in  1  key state from keyer, clk-synchronous.
- sample_tick  in  1  one-clk strobe at audio rate (48 kHz).
- sidetone  out  16  signed tone sample.
- sidetone_valid  out  1  one-clk strobe marking a new sample.
- sidetone_active  out  1  high while envelope state is not IDLE.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - volume = 8'h40, enable = 1, freq = 12'd600.
  - phase = 0, env = 0, state = IDLE.
  - sidetone = 0, sidetone_valid = 0, sidetone_active = 0.
- Register writes (applied on the clk with `cmd_rqst` high):
  - cmd_addr 6'h0F: volume <= data[7:0], enable <= data[8].
  - cmd_addr 6'h10: freq <= data[11:0].
  - Any other address: ignored.
  - freq > FREQ_MAX is stored as FREQ_MAX.
- Phase-increment computation:
  - inc = freq * INC_SCALE, as a 24-bit unsigned value (max 1.4M, no overflow).
  - It is a registered product, so freq updates take effect on the first sample_tick at least 2 clks after the write.
- Effective key: key = cw_keydown & enable & (volume != 0).
- State machine, advancing only on sample_tick:
  - IDLE: env = 0, phase held at 0. key -> RISE.
  - RISE: env += ENV_STEP, saturating at 255. Reaching 255 -> HOLD. !key -> FALL, continuing from the current env.
  - HOLD: env = 255. !key -> FALL.
  - FALL: env -= ENV_STEP, saturating at 0. Reaching 0 -> IDLE and phase <= 0. key -> RISE, continuing from the current env (no reset to 0, no click).
  - Key changes between ticks are sampled only at a tick.
- Phase: on each tick in a non-IDLE state, phase <= phase + inc, modulo 2^24 (natural wrap).
- Triangle waveform:
  - u = phase[23] ? ~phase[22:8] : phase[22:8] (15-bit unsigned).
  - tri = 2u − 32767, computed in 17 bits, result range ±32767.
- Output pipeline, launched by sample_tick:
  - clk+1: p1 = tri * env (signed 24-bit).
  - clk+2: p2 = p1 * volume (signed 32-bit).
  - clk+3: sidetone <= p2[31:16], sidetone_valid = 1 for one clk.
  - Latency from tick to valid is exactly 3 clks.
  - Values used are those latched at the tick; a tick arriving inside the pipeline is unsupported (ticks are ≥ 200 clks apart).
- IDLE output: sidetone is exactly 0, and sidetone_valid still strobes every tick.
- Enable cleared or volume set to 0 mid-tone: key goes low, so the tone ramps down through FALL with no step.
- sidetone_active = (state != IDLE), registered.
- Reset mid-tone: all outputs go to their reset values immediately; the pipeline contents are discarded.

Test Plan:
- Reset release, no stimulus, 10 ticks:
  - sidetone = 0 on every tick; valid strobes exactly 3 clks after each tick; sidetone_active = 0.
- Defaults, cw_keydown held high:
  - RISE → HOLD after 255 ticks, env = 255.
  - inc = 210000; zero crossings ≈ every 39.9 ticks.
  - Peak |sidetone| = (32767·255·64)>>16 ≈ 8159 ±1.
- Release cw_keydown at HOLD:
  - 255 ticks of monotonically decreasing amplitude, then IDLE, sidetone_active = 0, phase = 0.
- Press for 100 ticks, release, re-press at env = 40:
  - env falls 100 → 40, then rises from 40 with no discontinuity greater than 1 step.
- Write addr 0x0F data 0x100 mid-HOLD (volume = 0):
  - Output scaled to 0 and FALL entered; sidetone_active drops after 255 ticks.
- Write addr 0x10 data 5000, then assert rst mid-tone:
  - Stored freq = 4000, inc = 1400000.
  - On rst: sidetone = 0 and state = IDLE without waiting for a clk edge; after release, freq = 600.
